// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Purpose  : Shared definitions for the MEM-stage data-memory controller:
//            memory op codes, FSM state encoding and a store-classifier helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

  // Memory operation codes presented on req_op
  localparam logic [2:0] LW  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LHU = 3'd2;
  localparam logic [2:0] LB  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] SW  = 3'd5;
  localparam logic [2:0] SH  = 3'd6;
  localparam logic [2:0] SB  = 3'd7;

  // Controller FSM states
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

  // Op codes 5..7 are stores; 4 (LBU) shares the top bit but is a load.
  function automatic logic is_store(input logic [2:0] op);
    return op[2] && (op != LBU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane.sv
`default_nettype none
// ============================================================================
// Module   : dm_lane
// Purpose  : Purely combinational byte-lane logic. Extracts and extends the
//            addressed byte/halfword/word for loads, builds the merged word
//            for sub-word stores and flags misaligned accesses.
// Ports    : word      in  32  memory word at the accessed word address
//            addr_lo   in  2   byte offset within the word
//            op        in  3   memory op code (dm_pkg)
//            wdata     in  32  store data (low byte / halfword for SB/SH)
//            load_data out 32  extended load result (0 for stores)
//            merged    out 32  word to write back (wdata itself for SW)
//            misalign  out 1   access violates its natural alignment
// Revision : 1.0 - initial release
// ============================================================================
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged,
  output logic        misalign
);

  logic [4:0]  byte_lsb;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian: byte k lives at bits [8k+7:8k]
  assign byte_lsb = {addr_lo, 3'b000};
  assign byte_sel = word[byte_lsb +: 8];
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = 32'h0;
    case (op)
      LW:      load_data = word;
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'h0, half_sel};
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'h0, byte_sel};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    merged = wdata;
    case (op)
      SB: begin
        merged = word;
        merged[byte_lsb +: 8] = wdata[7:0];
      end
      SH: begin
        merged = word;
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    case (op)
      LW, SW:      misalign = |addr_lo;
      LH, LHU, SH: misalign = addr_lo[0];
      default:     misalign = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_ctrl
// Purpose  : MEM-stage data-memory controller. Converts byte-addressed
//            loads/stores into word accesses on a word-only data memory.
//            Sub-word stores use a two-cycle read-modify-write (read in
//            IDLE, write in MERGE) and stall the pipeline for one cycle.
// Ports    : clk, rst            clock, synchronous active-high reset
//            req_valid/op/addr/wdata  request from the MEM stage
//            rdata     out 32    extended load result (accept cycle)
//            stall     out 1     hold MEM and upstream stages
//            adel/ades out 1     misaligned load / store pulse
//            dm_addr   out AW    word address to data memory
//            dm_din    out 32    write data to data memory
//            dm_we     out 1     data memory write enable
//            dm_dout   in  32    combinational read data from data memory
// Revision : 1.0 - initial release
// ============================================================================
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [2:0]    req_op,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          adel,
  output logic          ades,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic          dm_we,
  input  logic [31:0]   dm_dout
);

  logic [0:0]    state;
  logic [31:0]   merge_buf;
  logic [AW-1:0] wr_addr;

  logic [AW-1:0] req_word;
  logic [31:0]   lane_load;
  logic [31:0]   lane_merged;
  logic          lane_misalign;
  logic          req_store;
  logic          req_subword_store;

  // Address bits above the memory size are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign req_word          = req_addr[AW+1:2];
  assign req_store         = is_store(req_op);
  assign req_subword_store = (req_op == SB) || (req_op == SH);

  dm_lane u_lane (
    .word      (dm_dout),
    .addr_lo   (req_addr[1:0]),
    .op        (req_op),
    .wdata     (req_wdata),
    .load_data (lane_load),
    .merged    (lane_merged),
    .misalign  (lane_misalign)
  );

  always_comb begin
    dm_addr = req_word;
    dm_din  = req_wdata;
    dm_we   = 1'b0;
    stall   = 1'b0;
    adel    = 1'b0;
    ades    = 1'b0;
    rdata   = 32'h0;
    if (rst) begin
      // All side effects suppressed; a pending MERGE write is dropped here.
      dm_addr = req_word;
    end else if (state == MERGE) begin
      // Request inputs are ignored: the write-back half of the RMW.
      dm_addr = wr_addr;
      dm_din  = merge_buf;
      dm_we   = 1'b1;
    end else if (req_valid) begin
      if (lane_misalign) begin
        adel = ~req_store;
        ades = req_store;
      end else if (!req_store) begin
        rdata = lane_load;
      end else if (req_op == SW) begin
        dm_we = 1'b1;
      end else begin
        // SB/SH read phase: hold the pipeline while the merged word is latched.
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      merge_buf <= 32'h0;
      wr_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_subword_store && !lane_misalign) begin
            merge_buf <= lane_merged;
            wr_addr   <= req_word;
            state     <= MERGE;
          end
        end
        MERGE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_ctrl
// Purpose  : Self-checking bench for dm_ctrl. Models the data memory, keeps a
//            byte-level reference memory, pushes expected responses into a
//            scoreboard queue and compares them in an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_ctrl;
  import dm_pkg::*;

  localparam int AW = 10;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [2:0]    req_op;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   rdata;
  logic          stall;
  logic          adel;
  logic          ades;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_din;
  logic          dm_we;
  logic [31:0]   dm_dout;

  always #5 clk = ~clk;

  dm_ctrl #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rdata     (rdata),
    .stall     (stall),
    .adel      (adel),
    .ades      (ades),
    .dm_addr   (dm_addr),
    .dm_din    (dm_din),
    .dm_we     (dm_we),
    .dm_dout   (dm_dout)
  );

  // Data memory: synchronous write, combinational read
  logic [31:0] mem [NW];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NW; i++) mem[i] <= 32'h0;
    end else if (dm_we) begin
      mem[dm_addr] <= dm_din;
    end
  end
  assign dm_dout = mem[dm_addr];

  // Reference model state
  logic [31:0] ref_mem [NW];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] op);
    if (op == LW || op == SW) return 4;
    if (op == LH || op == LHU || op == SH) return 2;
    return 1;
  endfunction

  function automatic bit op_is_store(input logic [2:0] op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] v;
    v = ref_mem[addr[AW+1:2]] >> (8 * int'(addr[1:0]));
    case (op)
      LB:      begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      LBU:     v = v % 256;
      LH:      begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      LHU:     v = v % 65536;
      LW:      v = v;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int          sh;
    int          idx;
    idx  = int'(addr[AW+1:2]);
    sh   = 8 * int'(addr[1:0]);
    mask = (size_of(op) == 4) ? 32'hFFFF_FFFF : (size_of(op) == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
  endtask

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic        we;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];

  // Issue one request; expected response goes to the scoreboard first.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input string name);
    exp_t e;
    bit   st;
    bit   mis;
    int   n;
    st  = op_is_store(op);
    mis = (int'(addr[1:0]) % size_of(op)) != 0;
    e.name   = name;
    e.adel   = mis && !st;
    e.ades   = mis && st;
    e.rdata  = (!st && !mis) ? ref_load(op, addr) : 32'h0;
    e.we     = st && !mis;
    e.stalls = (st && !mis && size_of(op) < 4) ? 1 : 0;
    if (st && !mis) ref_store(op, addr, wdata);
    exp_q.push_back(e);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 10);
    check({name, "/stall_timeout"}, {31'h0, stall}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Monitor: a request completes in the cycle it is valid without stall.
  int   stall_cnt = 0;
  exp_t m;
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt = 0;
    end else begin
      if (stall) begin
        stall_cnt++;
        check("we_while_stalled", {31'h0, dm_we}, 32'h0);
      end
      if (req_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion actual=op%0d required=none", req_op);
        end else begin
          m = exp_q.pop_front();
          check({m.name, "/rdata"},  rdata,             m.rdata);
          check({m.name, "/adel"},   {31'h0, adel},     {31'h0, m.adel});
          check({m.name, "/ades"},   {31'h0, ades},     {31'h0, m.ades});
          check({m.name, "/we"},     {31'h0, dm_we},    {31'h0, m.we});
          check({m.name, "/stalls"}, stall_cnt,         m.stalls);
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  op;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
    rst       = 1'b1;
    mem_init  = 1'b1;
    req_valid = 1'b1;
    req_op    = SH;
    req_addr  = 32'h85;
    req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    // Outputs are quiet while reset is held, even with a request present
    @(negedge clk);
    check("rst/we",    {31'h0, dm_we}, 32'h0);
    check("rst/stall", {31'h0, stall}, 32'h0);
    check("rst/ades",  {31'h0, ades},  32'h0);
    req_op   = LW;
    req_addr = 32'h86;
    @(negedge clk);
    check("rst/adel",  {31'h0, adel},  32'h0);
    check("rst/rdata", rdata,          32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_init  = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("idle/stall", {31'h0, stall}, 32'h0);
    check("idle/we",    {31'h0, dm_we}, 32'h0);
    check("idle/rdata", rdata,          32'h0);
    check("idle/adel",  {31'h0, adel},  32'h0);
    @(posedge clk);
    #1;

    // Directed scenarios
    do_req(SW,  32'h80, 32'h1234_F678, "sw80");
    do_req(LB,  32'h81, 32'h0,         "lb81");
    do_req(LBU, 32'h81, 32'h0,         "lbu81");
    do_req(SW,  32'h10, 32'h8001_7FFF, "sw10");
    do_req(LH,  32'h12, 32'h0,         "lh12");
    do_req(LHU, 32'h12, 32'h0,         "lhu12");
    do_req(LH,  32'h10, 32'h0,         "lh10");
    do_req(SW,  32'h20, 32'hAABB_CCDD, "sw20");
    do_req(SB,  32'h22, 32'h0000_0011, "sb22");
    do_req(LW,  32'h20, 32'h0,         "lw20");
    do_req(SH,  32'h31, 32'hFFFF_FFFF, "sh31_mis");
    do_req(LW,  32'h32, 32'h0,         "lw32_mis");
    do_req(LW,  32'h30, 32'h0,         "lw30_untouched");
    do_req(SW,  32'h40, 32'h0,         "sw40");
    do_req(SB,  32'h40, 32'h0000_0001, "sb40");
    do_req(SB,  32'h43, 32'h0000_0002, "sb43");
    do_req(LW,  32'h40, 32'h0,         "lw40");
    check("mem40_word", mem[16], 32'h0200_0001);
    check("mem20_word", mem[8],  32'hAA11_CCDD);

    // Reset arriving during MERGE drops the pending write
    do_req(SW, 32'h50, 32'h1234_5678, "sw50");
    req_valid = 1'b1;
    req_op    = SH;
    req_addr  = 32'h50;
    req_wdata = 32'h0000_BEEF;
    @(negedge clk);
    check("rstmerge/stallA", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmerge/we", {31'h0, dm_we}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmerge/stall_after", {31'h0, stall}, 32'h0);
    check("rstmerge/we_after",    {31'h0, dm_we}, 32'h0);
    check("rstmerge/mem",         mem[20],        32'h1234_5678);
    @(posedge clk);
    #1;
    do_req(LW, 32'h50, 32'h0, "lw50");

    // Randomized traffic over a small window of words, upper address bits noise
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_F000) | ((32'h100 + 32'($urandom_range(0, 7))) << 2)
           | 32'($urandom_range(0, 3));
      do_req(op, a, $urandom, "rnd");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);
    for (int i = 0; i < NW; i++) begin
      if (mem[i] !== ref_mem[i]) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
      else checks++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
